// File: rtl/oka_64bit.sv
// ----------------------------------------------------------------------------
// oka_64bit
//   Two-stage pipelined 64x64 carry-less multiplier over GF(2)[x], built with
//   the Overlap-free Karatsuba Algorithm (OKA). The result is the unreduced
//   127-bit polynomial product; reduction happens downstream.
//
//   Decomposition: 64 -> 32 -> 16 -> 8. The 8x8 leaves are schoolbook
//   AND/XOR arrays; every level above recombines its three sub-products
//   (L, H, M) with XORs only.
//
//   Stage 1 registers L = Al*Bl, H = Ah*Bh, M = (Al^Ah)*(Bl^Bh), each a
//   63-bit product of 32-bit halves, together with a valid bit.
//   Stage 2 registers the recombined product y and out_valid.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset; clears every pipeline register
//   a, b       64-bit operands, bit i = coefficient of x^i
//   in_valid   operands are accepted on a rising edge where this is high
//   y          127-bit product, bit k = coefficient of x^k
//   out_valid  one-cycle pulse aligned with y for each accepted operand pair
//
// Handshake: valid-only, no ready. Every rising edge where in_valid = 1
// accepts one operand pair; out_valid = 1 appears exactly once for it, two
// register stages later. There is no backpressure, so downstream must take
// y in the cycle out_valid is high. The registers load every cycle, so y
// is only meaningful while out_valid = 1.
// ----------------------------------------------------------------------------
module oka_64bit (
    input  logic         clk,
    input  logic         rst,
    input  logic [63:0]  a,
    input  logic [63:0]  b,
    input  logic         in_valid,
    output logic [126:0] y,
    output logic         out_valid
);

    // 8x8 schoolbook leaf: every partial product a[i]&b[j] lands on x^(i+j).
    function automatic logic [14:0] clmul8(input logic [7:0] x, input logic [7:0] z);
        logic [14:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                r[i+j] = r[i+j] ^ (x[i] & z[j]);
            end
        end
        return r;
    endfunction

    // 16x16 OKA step on 8-bit halves -> 31-bit product.
    function automatic logic [30:0] oka16(input logic [15:0] x, input logic [15:0] z);
        logic [14:0] l;
        logic [14:0] h;
        logic [14:0] m;
        logic [14:0] c;
        l = clmul8(x[7:0], z[7:0]);
        h = clmul8(x[15:8], z[15:8]);
        m = clmul8(x[7:0] ^ x[15:8], z[7:0] ^ z[15:8]);
        c = m ^ l ^ h;
        return {16'b0, l} ^ {8'b0, c, 8'b0} ^ {h, 16'b0};
    endfunction

    // 32x32 OKA step on 16-bit halves -> 63-bit product.
    function automatic logic [62:0] oka32(input logic [31:0] x, input logic [31:0] z);
        logic [30:0] l;
        logic [30:0] h;
        logic [30:0] m;
        logic [30:0] c;
        l = oka16(x[15:0], z[15:0]);
        h = oka16(x[31:16], z[31:16]);
        m = oka16(x[15:0] ^ x[31:16], z[15:0] ^ z[31:16]);
        c = m ^ l ^ h;
        return {32'b0, l} ^ {16'b0, c, 16'b0} ^ {h, 32'b0};
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: three 32x32 sub-products
    // ------------------------------------------------------------------
    logic [62:0] l_q;
    logic [62:0] h_q;
    logic [62:0] m_q;
    logic        v1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_q  <= '0;
            h_q  <= '0;
            m_q  <= '0;
            v1_q <= 1'b0;
        end else begin
            l_q  <= oka32(a[31:0], b[31:0]);
            h_q  <= oka32(a[63:32], b[63:32]);
            m_q  <= oka32(a[31:0] ^ a[63:32], b[31:0] ^ b[63:32]);
            v1_q <= in_valid;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: overlap-free recombination y = L ^ (C << 32) ^ (H << 64)
    // L spans bits 0..62, C<<32 spans 32..94, H<<64 spans 64..126. Bit 63
    // is touched only by C[31] and bit 95 only by H[31]; every other
    // segment is a plain XOR of at most two slices.
    // ------------------------------------------------------------------
    logic [62:0]  c_mid;
    logic [126:0] y_next;

    always_comb begin
        c_mid          = m_q ^ l_q ^ h_q;
        y_next         = '0;
        y_next[31:0]   = l_q[31:0];
        y_next[62:32]  = l_q[62:32] ^ c_mid[30:0];
        y_next[63]     = c_mid[31];
        y_next[94:64]  = c_mid[62:32] ^ h_q[30:0];
        y_next[95]     = h_q[31];
        y_next[126:96] = h_q[62:32];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y         <= '0;
            out_valid <= 1'b0;
        end else begin
            y         <= y_next;
            out_valid <= v1_q;
        end
    end

endmodule

// File: tb/tb_oka_64bit.sv
// ----------------------------------------------------------------------------
// tb_oka_64bit
//   Self-checking bench for oka_64bit. Reference: the defining sum
//   y = XOR over set bits i of a of (b << i), computed on 127-bit vectors.
//   Expected entries {valid, product} go into exp_q as operands are driven;
//   the entry pushed at one rising edge is due on the outputs just after the
//   following rising edge (two register stages).
// ----------------------------------------------------------------------------
module tb_oka_64bit;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  a;
  logic [63:0]  b;
  logic         in_valid;
  logic [126:0] y;
  logic         out_valid;

  int errors = 0;
  int checks = 0;

  logic [127:0] exp_q[$];

  oka_64bit dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .y         (y),
    .out_valid (out_valid)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [126:0] clmul_ref(input logic [63:0] x, input logic [63:0] z);
    logic [126:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (x[i]) r = r ^ ({63'b0, z} << i);
    end
    return r;
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle of operands, lets one rising edge pass, samples 1 time
  // unit later, and hands back the expectation that is due now (if any).
  task automatic drive_cycle(input logic [63:0] ta, input logic [63:0] tb_v, input logic tv,
                             output logic have, output logic [127:0] exp_e);
    a        = ta;
    b        = tb_v;
    in_valid = tv;
    @(posedge clk);
    #1;
    exp_q.push_back({tv, clmul_ref(ta, tb_v)});
    have  = 1'b0;
    exp_e = '0;
    if (exp_q.size() > 1) begin
      exp_e = exp_q.pop_front();
      have  = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset_initial;
    checks++;
    if (y !== 127'b0) begin
      errors++;
      $display("FAIL reset_initial_y: got %h expected 0", y);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial_valid: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_directed;
    logic [63:0]  va[6];
    logic [63:0]  vb[6];
    logic [126:0] vy[6];
    logic [127:0] ones_pat;
    logic         have;
    logic [127:0] e;
    ones_pat = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
    va[0] = 64'd1;                   vb[0] = 64'hDEADBEEF_01234567; vy[0] = 127'hDEADBEEF_01234567;
    va[1] = 64'd0;                   vb[1] = '1;                    vy[1] = '0;
    va[2] = 64'd3;                   vb[2] = 64'd3;                 vy[2] = 127'd5;
    va[3] = 64'h8000_0000_0000_0000; vb[3] = 64'h8000_0000_0000_0000; vy[3] = 127'd1 << 126;
    va[4] = '1;                      vb[4] = '1;                    vy[4] = ones_pat[126:0];
    va[5] = 64'hF618_F618_F618_F618; vb[5] = 64'hEE48_EE48_EE48_EE48;
    vy[5] = clmul_ref(va[5], vb[5]);
    for (int n = 0; n < 6; n++) begin
      // the pop here belongs to the previous cycle (idle or earlier test)
      drive_cycle(va[n], vb[n], 1'b1, have, e);
      if (have) begin
        checks++;
        if (out_valid !== e[127]) begin
          errors++;
          $display("FAIL directed_prev_valid[%0d]: got %b expected %b", n, out_valid, e[127]);
        end
      end
      drive_cycle(64'd0, 64'd0, 1'b0, have, e);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL directed_valid[%0d]: got %b expected 1", n, out_valid);
      end
      checks++;
      if (y !== vy[n]) begin
        errors++;
        $display("FAIL directed_y[%0d]: got %h expected %h", n, y, vy[n]);
      end
    end
  endtask

  task automatic test_pipeline;
    logic         pat[10];
    logic         have;
    logic [127:0] e;
    logic [63:0]  ra;
    logic [63:0]  rb;
    pat = '{1, 1, 1, 1, 1, 0, 1, 1, 0, 0};
    for (int n = 0; n < 10; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      drive_cycle(ra, rb, pat[n], have, e);
      if (have) begin
        checks++;
        if (out_valid !== e[127]) begin
          errors++;
          $display("FAIL pipeline_valid[%0d]: got %b expected %b", n, out_valid, e[127]);
        end
        if (e[127]) begin
          checks++;
          if (y !== e[126:0]) begin
            errors++;
            $display("FAIL pipeline_y[%0d]: got %h expected %h", n, y, e[126:0]);
          end
        end
      end
    end
  endtask

  task automatic test_random;
    logic         have;
    logic [127:0] e;
    logic [63:0]  ra;
    logic [63:0]  rb;
    logic         rv;
    for (int n = 0; n < 10002; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rv = (n < 10000) ? ($urandom_range(0, 3) != 0) : 1'b0;
      drive_cycle(ra, rb, rv, have, e);
      if (have) begin
        checks++;
        if (out_valid !== e[127]) begin
          errors++;
          $display("FAIL random_valid[%0d]: got %b expected %b", n, out_valid, e[127]);
        end
        if (e[127]) begin
          checks++;
          if (y !== e[126:0]) begin
            errors++;
            $display("FAIL random_y[%0d]: a=%h b=%h got %h expected %h", n, ra, rb, y, e[126:0]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midstream;
    logic         have;
    logic [127:0] e;
    logic [63:0]  fa;
    logic [63:0]  fb;
    // two valid operations enter the pipe, a third is presented
    drive_cycle(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, have, e);
    drive_cycle(64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, have, e);
    a        = 64'hAAAA_AAAA_AAAA_AAAA;
    b        = 64'h5555_5555_5555_5555;
    in_valid = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (y !== 127'b0) begin
      errors++;
      $display("FAIL reset_mid_y: got %h expected 0", y);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_valid: got %b expected 0", out_valid);
    end
    // in-flight work is discarded
    exp_q.delete();
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // no out_valid may surface for the discarded operations
    for (int n = 0; n < 3; n++) begin
      drive_cycle(64'd0, 64'd0, 1'b0, have, e);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_ghost_valid[%0d]: got %b expected 0", n, out_valid);
      end
    end
    // first operation after release goes straight through
    fa = {$urandom, $urandom};
    fb = {$urandom, $urandom};
    drive_cycle(fa, fb, 1'b1, have, e);
    drive_cycle(64'd0, 64'd0, 1'b0, have, e);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_after_valid: got %b expected 1", out_valid);
    end
    checks++;
    if (y !== e[126:0] || e[127] !== 1'b1) begin
      errors++;
      $display("FAIL reset_after_y: got %h expected %h", y, e[126:0]);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst      = 1'b1;
    a        = '0;
    b        = '0;
    in_valid = 1'b0;
    #1;
    test_reset_initial();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_directed();
    test_pipeline();
    test_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
